fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 fetch_en  input  1  1 = fetching permitted; 0 = pause fetch (queue still drains).
REQ-005 im_addr  output  32  address to instruction memory, combinational from fetch PC.
REQ-006 im_inst  input  32  instruction word returned combinationally by memory for im_addr.
REQ-007 redirect_valid  input  1  branch/jump redirect request.
REQ-008 redirect_pc  input  32  redirect target.
REQ-009 if_valid  output  1  queue head holds an instruction for decode.
REQ-010 if_ready  input  1  decode accepts head this cycle.
REQ-011 if_inst  output  32  head instruction.
REQ-012 if_pc  output  32  PC of head instruction.
REQ-013 fault  output  1  sticky misaligned-redirect fault.

Function
REQ-014 Block SHALL hold fetch PC register fpc and a 2-entry FIFO of {pc, inst} pairs, count 0..2.
REQ-015 im_addr SHALL equal fpc at all times.
REQ-016 FSM states SHALL be IDLE, RUN, FAULT; reset state IDLE.
REQ-017 IDLE->RUN when fetch_en=1 sampled; RUN->IDLE when fetch_en=0 sampled; FAULT exits only by reset.
REQ-018 Push: in RUN with redirect_valid=0 and (count<2 or pop this cycle), SHALL write {fpc, im_inst} to tail and set fpc = fpc+4.
REQ-019 Pop: when if_valid=1 and if_ready=1, head SHALL be removed; simultaneous push and pop SHALL leave count unchanged, including at count=2.
REQ-020 if_valid SHALL be 1 iff count!=0 and state!=FAULT; if_inst/if_pc SHALL show head entry, zero when count=0.
REQ-021 fpc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 Redirect (highest priority, any state except FAULT) with redirect_pc[1:0]==0: count SHALL become 0, fpc SHALL become redirect_pc, no push that cycle; a coincident pop is considered accepted then discarded.
REQ-023 Redirect with redirect_pc[1:0]!=0: state SHALL become FAULT, fault=1, count=0, fpc unchanged.
REQ-024 In FAULT no push, no pop, if_valid=0, fault held at 1.
REQ-025 Latency: fetch_en first sampled 1 at edge N -> push at edge N+1 -> if_valid=1 after edge N+1.
REQ-026 In IDLE, entries already queued SHALL remain and drain normally; fpc holds, resume continues from fpc.
REQ-027 Steady state RUN with if_ready=1 constantly SHALL deliver one instruction per cycle with no bubbles.

Reset
REQ-028 On rst_n=0, asynchronously: fpc=RESET_PC, count=0, state IDLE, fault=0, if_valid=0, if_inst=0, if_pc=0.
REQ-029 Reset asserted mid-operation SHALL discard queued entries; first fetch after release follows REQ-025 from RESET_PC.

Verification
REQ-030 Reset release, fetch_en=1, if_ready=1, memory word k = 0x1000+k -> if_pc 0x0,0x4,0x8 on consecutive cycles with if_inst 0x1000,0x1001,0x1002, first valid two edges after fetch_en sampled.
REQ-031 if_ready=0 for 5 cycles in RUN -> count saturates at 2, fpc stops at 0x8, im_addr=0x8; if_ready=1 -> if_pc 0x0,0x4,0x8 in order, no duplicates/gaps.
REQ-032 Queue full, redirect_valid=1 redirect_pc=0x40 with if_ready=1 -> next cycle if_valid=0, im_addr=0x40; following cycle if_pc=0x40.
REQ-033 redirect_pc=0x42 -> fault=1, if_valid=0 indefinitely regardless of fetch_en/redirect; rst_n pulse -> fault=0, im_addr=RESET_PC.
REQ-034 RESET_PC=32'hFFFF_FFF8, run 3 fetches -> if_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-035 fetch_en dropped with count=2, if_ready=1 -> two entries drain, then if_valid=0, fpc unchanged; fetch_en=1 resumes at that fpc.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction fetch controller. Holds the fetch PC, reads the
//                instruction memory combinationally and queues {pc, inst}
//                pairs in a 2-entry FIFO for decode. Aligned redirects flush
//                the queue; misaligned redirects lock the block in FAULT.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] im_addr,
  input  logic [31:0] im_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        fault
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_FAULT = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_fpc;
  logic [1:0]  r_count;
  // Entry 0 is always the head; entry 1 is valid only when count is 2.
  logic [31:0] r_pc0, r_pc1;
  logic [31:0] r_inst0, r_inst1;

  logic w_pop;
  logic w_push;
  logic w_redir;
  logic w_misal;

  // Handshake and control decode.
  always_comb begin
    w_redir  = redirect_valid && (r_state != c_FAULT);
    w_misal  = |redirect_pc[1:0];
    w_pop    = if_valid && if_ready;
    // A pop frees a slot in the same cycle, so a full queue still accepts.
    w_push   = (r_state == c_RUN) && !redirect_valid && ((r_count != 2'd2) || w_pop);
  end

  // Head presentation; zeros when empty so decode never sees stale data.
  always_comb begin
    im_addr  = r_fpc;
    fault    = (r_state == c_FAULT);
    if_valid = (r_count != 2'd0) && (r_state != c_FAULT);
    if_pc    = (r_count != 2'd0) ? r_pc0   : 32'h0;
    if_inst  = (r_count != 2'd0) ? r_inst0 : 32'h0;
  end

  // Control state: FAULT is terminal until reset, otherwise follow fetch_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else if (r_state == c_FAULT) begin
      r_state <= c_FAULT;
    end else if (w_redir && w_misal) begin
      r_state <= c_FAULT;
    end else if (fetch_en) begin
      r_state <= c_RUN;
    end else begin
      r_state <= c_IDLE;
    end
  end

  // Fetch PC: aligned redirect wins, otherwise advance on every push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc <= RESET_PC;
    end else if (w_redir && !w_misal) begin
      r_fpc <= redirect_pc;
    end else if (w_push) begin
      r_fpc <= r_fpc + 32'd4;
    end
  end

  // Two-entry queue; any redirect (aligned or not) empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      r_pc0   <= 32'h0;
      r_pc1   <= 32'h0;
      r_inst0 <= 32'h0;
      r_inst1 <= 32'h0;
    end else if (w_redir) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b01: begin
          r_pc0   <= r_pc1;
          r_inst0 <= r_inst1;
          r_count <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_pc0   <= r_fpc;
            r_inst0 <= im_inst;
          end else begin
            r_pc1   <= r_fpc;
            r_inst1 <= im_inst;
          end
          r_count <= r_count + 2'd1;
        end
        2'b11: begin
          // Count unchanged: the new word lands behind whatever remains.
          if (r_count == 2'd1) begin
            r_pc0   <= r_fpc;
            r_inst0 <= im_inst;
          end else begin
            r_pc0   <= r_pc1;
            r_inst0 <= r_inst1;
            r_pc1   <= r_fpc;
            r_inst1 <= im_inst;
          end
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl with a queue-based
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] im_addr;
  logic [31:0] im_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        fault;

  logic        hi_fetch_en;
  logic [31:0] hi_im_addr;
  logic [31:0] hi_im_inst;
  logic        hi_if_valid;
  logic [31:0] hi_if_inst;
  logic [31:0] hi_if_pc;
  logic        hi_fault;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  assign im_inst    = mem_word(im_addr);
  assign hi_im_inst = mem_word(hi_im_addr);

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .im_addr(im_addr), .im_inst(im_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .fault(fault)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
    .clk(clk), .rst_n(rst_n), .fetch_en(hi_fetch_en),
    .im_addr(hi_im_addr), .im_inst(hi_im_inst),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_valid(hi_if_valid), .if_ready(1'b1),
    .if_inst(hi_if_inst), .if_pc(hi_if_pc), .fault(hi_fault)
  );

  // Reference model: queue of {pc, inst}, fetch PC, running and faulted flags.
  logic [63:0] m_q[$];
  logic [31:0] m_fpc;
  bit          m_run;
  bit          m_faulted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fpc     = 32'h0;
    m_run     = 1'b0;
    m_faulted = 1'b0;
  endtask

  // One rising edge of behaviour, evaluated from the inputs held before it.
  task automatic model_edge();
    bit pop;
    if (m_faulted) return;
    pop = (m_q.size() > 0) && if_ready;
    if (redirect_valid) begin
      m_q.delete();
      if (redirect_pc[1:0] != 2'b00) m_faulted = 1'b1;
      else m_fpc = redirect_pc;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_run && m_q.size() < 2) begin
        m_q.push_back({m_fpc, mem_word(m_fpc)});
        m_fpc = m_fpc + 32'd4;
      end
    end
    if (!m_faulted) m_run = fetch_en;
  endtask

  task automatic compare_all(input string tag);
    logic [63:0] head;
    bit          vld;
    vld  = !m_faulted && (m_q.size() > 0);
    head = (m_q.size() > 0) ? m_q[0] : 64'h0;
    check({tag, ".im_addr"},  im_addr,          m_fpc);
    check({tag, ".if_valid"}, {31'h0, if_valid}, {31'h0, vld});
    check({tag, ".if_pc"},    if_pc,            head[63:32]);
    check({tag, ".if_inst"},  if_inst,          head[31:0]);
    check({tag, ".fault"},    {31'h0, fault},   {31'h0, m_faulted});
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    @(posedge clk);
    #1;
    compare_all("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] saved_pc;
  int          fault_age;

  initial begin
    rst_n = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; if_ready = 1'b0; hi_fetch_en = 1'b0;
    model_reset();
    do_reset();

    // First fetch latency and a wrapping PC on the high-reset instance.
    fetch_en = 1'b1; if_ready = 1'b1; hi_fetch_en = 1'b1;
    step("lat0");
    check("lat0.not_yet_valid", {31'h0, if_valid}, 32'h0);
    step("lat1");
    check("lat1.pc", if_pc, 32'h0);     check("lat1.inst", if_inst, 32'h1000);
    check("hi1.pc", hi_if_pc, 32'hFFFF_FFF8);
    step("lat2");
    check("lat2.pc", if_pc, 32'h4);     check("lat2.inst", if_inst, 32'h1001);
    check("hi2.pc", hi_if_pc, 32'hFFFF_FFFC);
    step("lat3");
    check("lat3.pc", if_pc, 32'h8);     check("lat3.inst", if_inst, 32'h1002);
    check("hi3.pc", hi_if_pc, 32'h0000_0000);
    hi_fetch_en = 1'b0;

    // Backpressure: queue fills and fpc stalls, then drains in order.
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b0;
    for (int i = 0; i < 6; i++) step("stall");
    check("stall.im_addr", im_addr, 32'h8);
    if_ready = 1'b1;
    check("drain.pc0", if_pc, 32'h0);
    step("drain1"); check("drain.pc1", if_pc, 32'h4);
    step("drain2"); check("drain.pc2", if_pc, 32'h8);

    // Aligned redirect with a full queue and a coincident pop.
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("fill");
    redirect_valid = 1'b1; redirect_pc = 32'h40; if_ready = 1'b1;
    step("redir");
    check("redir.valid", {31'h0, if_valid}, 32'h0);
    check("redir.im_addr", im_addr, 32'h40);
    redirect_valid = 1'b0;
    step("redir_next");
    check("redir_next.pc", if_pc, 32'h40);

    // Pause with a full queue: drain, hold fpc, resume from it.
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("fill2");
    fetch_en = 1'b0; if_ready = 1'b1;
    for (int i = 0; i < 4; i++) step("pause");
    check("pause.valid", {31'h0, if_valid}, 32'h0);
    saved_pc = m_fpc;
    fetch_en = 1'b1;
    step("resume0"); step("resume1");
    check("resume.pc", if_pc, saved_pc);

    // Misaligned redirect is sticky until reset.
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step("mis");
    check("mis.fault", {31'h0, fault}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      fetch_en = 1'($urandom); redirect_valid = 1'($urandom);
      redirect_pc = {$urandom} & 32'hFFFF_FFFC; if_ready = 1'($urandom);
      step("fault_hold");
    end
    redirect_valid = 1'b0;
    do_reset();
    check("unfault.fault", {31'h0, fault}, 32'h0);
    check("unfault.im_addr", im_addr, 32'h0);

    // Random traffic against the model.
    fault_age = 0;
    for (int c = 0; c < 3000; c++) begin
      fetch_en       = ($urandom_range(0, 99) < 85);
      if_ready       = ($urandom_range(0, 99) < 60);
      redirect_valid = ($urandom_range(0, 99) < 5);
      redirect_pc    = {$urandom} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      step("rnd");
      fault_age = m_faulted ? fault_age + 1 : 0;
      if (fault_age > 5 || $urandom_range(0, 199) == 0) begin
        redirect_valid = 1'b0;
        do_reset();
        fault_age = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
